// File: rtl/prog_gray_timer_pkg.sv
// Shared types and 4-bit Gray helpers for the programmable Gray-code timer.
package prog_gray_timer_pkg;

  localparam int STG_W = 4;
  localparam logic [STG_W-1:0] GRAY_LAST = 4'b1000;

  typedef enum logic {
    TM_PERIODIC = 1'b0,
    TM_ONESHOT  = 1'b1
  } timer_mode_e;

  function automatic logic [STG_W-1:0] bin2gray4(input logic [STG_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [STG_W-1:0] gray2bin4(input logic [STG_W-1:0] g);
    logic [STG_W-1:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // Successor in the 16-entry Gray cycle; 4'b1000 rolls back to 4'b0000.
  function automatic logic [STG_W-1:0] next_gray4(input logic [STG_W-1:0] g);
    return bin2gray4(gray2bin4(g) + 4'd1);
  endfunction

endpackage

// File: rtl/prog_gray_timer_if.sv
// Control/status bundle between the timer and whoever programs and observes it.
interface prog_gray_timer_if
  import prog_gray_timer_pkg::*;
#(
  parameter int N_STG   = 5,
  parameter int PRESC_W = 8
);

  localparam int W = STG_W * N_STG;

  logic               en;
  logic               sclr;
  logic               load;
  logic [W-1:0]       load_val;
  logic [W-1:0]       period;
  timer_mode_e        mode;
  logic [PRESC_W-1:0] presc;

  logic [W-1:0]       cnt_gray;
  logic [W-1:0]       cnt_bin;
  logic               tc;
  logic               done;

  modport master (
    output en, sclr, load, load_val, period, mode, presc,
    input  cnt_gray, cnt_bin, tc, done
  );

  modport slave (
    input  en, sclr, load, load_val, period, mode, presc,
    output cnt_gray, cnt_bin, tc, done
  );

endinterface

// File: rtl/prog_gray_timer_gray_stage4.sv
// One 4-bit Gray-code counter digit; steps when cten is high and flags its last code.
module gray_stage4
  import prog_gray_timer_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cten,
  input  logic             sclr,
  input  logic             load,
  input  logic [STG_W-1:0] ld_gray,
  output logic [STG_W-1:0] gray,
  output logic             last
);

  logic [STG_W-1:0] gray_q, gray_d;

  always_comb begin
    gray_d = gray_q;
    if (sclr) begin
      gray_d = '0;
    end else if (load) begin
      gray_d = ld_gray;
    end else if (cten) begin
      gray_d = next_gray4(gray_q);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign gray = gray_q;
  assign last = (gray_q == GRAY_LAST);

endmodule

// File: rtl/prog_gray_timer.sv
// Programmable timer: prescaler, cascaded Gray digits, terminal compare, tc pulse and one-shot done.
module prog_gray_timer
  import prog_gray_timer_pkg::*;
#(
  parameter int N_STG   = 5,
  parameter int PRESC_W = 8
)
(
  input  logic            clk,
  input  logic            clr_n,
  prog_gray_timer_if.slave bus
);

  localparam int W = STG_W * N_STG;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tc_q, tc_d;
  logic               done_q, done_d;

  logic               tick;
  logic               advance;
  logic               terminal;
  logic               stageClr;
  logic [N_STG:0]     cten;
  logic [N_STG-1:0]   last;
  logic [W-1:0]       grayCnt;
  logic [W-1:0]       binCnt;
  logic               unusedCarry;

  // A terminal tick zeroes the digits unless a load claims the same edge.
  always_comb begin
    tick     = bus.en && (presc_q == bus.presc);
    advance  = tick && !done_q;
    terminal = advance && (binCnt == bus.period);
    stageClr = bus.sclr || (terminal && !bus.load);

    presc_d = presc_q;
    if (bus.sclr || bus.load || tick) begin
      presc_d = '0;
    end else if (bus.en) begin
      presc_d = presc_q + PRESC_W'(1);
    end

    tc_d = terminal && !bus.sclr && !bus.load;

    done_d = done_q;
    if (bus.sclr || bus.load) begin
      done_d = 1'b0;
    end else if (terminal && (bus.mode == TM_ONESHOT)) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      presc_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign cten[0] = advance;

  for (genvar k = 0; k < N_STG; k++) begin : g_stage
    logic [STG_W-1:0] ldGray;

    assign ldGray = bin2gray4(bus.load_val[k*STG_W +: STG_W]);

    gray_stage4 u_stage (
      .clk     (clk),
      .clr_n   (clr_n),
      .cten    (cten[k]),
      .sclr    (stageClr),
      .load    (bus.load),
      .ld_gray (ldGray),
      .gray    (grayCnt[k*STG_W +: STG_W]),
      .last    (last[k])
    );

    assign cten[k+1] = cten[k] && last[k];
    assign binCnt[k*STG_W +: STG_W] = gray2bin4(grayCnt[k*STG_W +: STG_W]);
  end

  // Carry out of the top digit is the natural 2^W-1 -> 0 wrap, which deliberately has no effect.
  assign unusedCarry = cten[N_STG];

  assign bus.cnt_gray = grayCnt;
  assign bus.cnt_bin  = binCnt;
  assign bus.tc       = tc_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_prog_gray_timer.sv
// Self-checking bench for prog_gray_timer: constant vector table, hand sequences, randomized model check.
module tb_prog_gray_timer;
  import prog_gray_timer_pkg::*;

  localparam int N_STG   = 5;
  localparam int PRESC_W = 8;
  localparam int W       = 4 * N_STG;

  typedef struct {
    logic               en;
    logic               sclr;
    logic               load;
    logic [W-1:0]       loadVal;
    logic [W-1:0]       period;
    timer_mode_e        mode;
    logic [PRESC_W-1:0] presc;
    int                 cycles;
    logic [W-1:0]       expBin;
    logic               expTc;
    logic               expDone;
  } vec_t;

  logic clk;
  logic clr_n;
  int   vectors;
  int   miscompares;

  logic [W-1:0]       mCnt;
  logic [PRESC_W-1:0] mPre;
  logic               mTc;
  logic               mDone;
  logic               mTick;

  vec_t vecs[24];

  prog_gray_timer_if #(.N_STG(N_STG), .PRESC_W(PRESC_W)) bus ();

  prog_gray_timer #(.N_STG(N_STG), .PRESC_W(PRESC_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: binary count plus prescaler, stepped from the behavioural rules each edge.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mCnt  = '0;
      mPre  = '0;
      mTc   = 1'b0;
      mDone = 1'b0;
    end else begin
      mTick = bus.en && (mPre == bus.presc);
      if (bus.sclr) begin
        mCnt = '0; mPre = '0; mTc = 1'b0; mDone = 1'b0;
      end else if (bus.load) begin
        mCnt = bus.load_val; mPre = '0; mTc = 1'b0; mDone = 1'b0;
      end else begin
        if (bus.en) mPre = mTick ? '0 : mPre + 1'b1;
        mTc = 1'b0;
        if (mTick && !mDone) begin
          if (mCnt == bus.period) begin
            mCnt = '0;
            mTc  = 1'b1;
            if (bus.mode == TM_ONESHOT) mDone = 1'b1;
          end else begin
            mCnt = mCnt + 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [W-1:0] stageGray(input logic [W-1:0] b);
    logic [W-1:0] g;
    logic [3:0]   d;
    g = '0;
    for (int k = 0; k < N_STG; k++) begin
      d = b[k*4 +: 4];
      g[k*4 +: 4] = d ^ {1'b0, d[3:1]};
    end
    return g;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] expBin,
                             input logic expTc, input logic expDone);
    logic [W-1:0] expGray;
    expGray = stageGray(expBin);
    vectors++;
    if (bus.cnt_bin !== expBin || bus.cnt_gray !== expGray ||
        bus.tc !== expTc || bus.done !== expDone) begin
      miscompares++;
      $display("[TB] FAIL %s: got bin=%h gray=%h tc=%b done=%b, expected bin=%h gray=%h tc=%b done=%b",
               name, bus.cnt_bin, bus.cnt_gray, bus.tc, bus.done, expBin, expGray, expTc, expDone);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mCnt, mTc, mDone);
  endtask

  task automatic setInputs(input logic en, input logic sclr, input logic load,
                           input logic [W-1:0] loadVal, input logic [W-1:0] period,
                           input timer_mode_e mode, input logic [PRESC_W-1:0] presc);
    bus.en = en; bus.sclr = sclr; bus.load = load; bus.load_val = loadVal;
    bus.period = period; bus.mode = mode; bus.presc = presc;
  endtask

  task automatic applyStimulus(input vec_t v);
    setInputs(v.en, v.sclr, v.load, v.loadVal, v.period, v.mode, v.presc);
    for (int c = 0; c < v.cycles; c++) stepCycle();
  endtask

  task automatic runChecked(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      stepCycle();
      checkModel(name);
    end
  endtask

  initial begin
    int tcCount;
    int firstTc;
    logic [W-1:0] lv;

    vectors     = 0;
    miscompares = 0;
    clr_n       = 1'b0;
    setInputs(1'b0, 1'b0, 1'b0, '0, '0, TM_PERIODIC, '0);

    //          en  sclr load loadVal       period        mode         presc cyc expBin        tc    done
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 20'h0,     20'hFFFFF, TM_PERIODIC, 8'd0, 3,  20'h00000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 20'h0,     20'hFFFFF, TM_PERIODIC, 8'd0, 17, 20'h00011, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 20'h0000F, 20'hFFFFF, TM_PERIODIC, 8'd0, 1,  20'h0000F, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00010, TM_PERIODIC, 8'd0, 1,  20'h00010, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00010, TM_PERIODIC, 8'd0, 1,  20'h00000, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00010, TM_PERIODIC, 8'd0, 1,  20'h00001, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00002, TM_ONESHOT,  8'd0, 2,  20'h00000, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00002, TM_ONESHOT,  8'd0, 3,  20'h00000, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 20'h00002, 20'h00002, TM_ONESHOT,  8'd0, 1,  20'h00002, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 20'h00007, 20'h00002, TM_ONESHOT,  8'd0, 1,  20'h00000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00000, TM_PERIODIC, 8'd0, 1,  20'h00000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00000, TM_PERIODIC, 8'd0, 1,  20'h00000, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 20'h0,     20'hFFFFF, TM_PERIODIC, 8'd3, 3,  20'h00000, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 20'h0,     20'hFFFFF, TM_PERIODIC, 8'd3, 1,  20'h00001, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 20'h0,     20'hFFFFF, TM_PERIODIC, 8'd3, 5,  20'h00001, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 20'h0,     20'hFFFFF, TM_PERIODIC, 8'd3, 4,  20'h00002, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 20'hFFFFE, 20'h00005, TM_PERIODIC, 8'd0, 1,  20'hFFFFE, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00005, TM_PERIODIC, 8'd0, 1,  20'hFFFFF, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00005, TM_PERIODIC, 8'd0, 1,  20'h00000, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00005, TM_PERIODIC, 8'd0, 5,  20'h00005, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00005, TM_PERIODIC, 8'd0, 1,  20'h00000, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 20'h0,     20'h00000, TM_PERIODIC, 8'd0, 1,  20'h00000, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 1'b1, 20'h00003, 20'h00000, TM_PERIODIC, 8'd0, 1,  20'h00003, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 1'b0, 20'h0,     20'h00003, TM_ONESHOT,  8'd0, 1,  20'h00000, 1'b1, 1'b1};

    stepCycle();
    stepCycle();
    checkOutput("reset", '0, 1'b0, 1'b0);
    clr_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].expBin, vecs[i].expTc, vecs[i].expDone);
    end

    // Free-running count with no prescale: binary +1 per cycle, Gray digits ripple.
    setInputs(1'b1, 1'b1, 1'b0, '0, 20'hFFFFF, TM_PERIODIC, 8'd0);
    stepCycle();
    bus.sclr = 1'b0;
    runChecked("freerun", 300);
    checkOutput("freerun_end", 20'd300, 1'b0, 1'b0);

    // Period 9 with divide-by-3 prescale: one tc per 30 cycles.
    setInputs(1'b1, 1'b1, 1'b0, '0, 20'd9, TM_PERIODIC, 8'd2);
    stepCycle();
    bus.sclr = 1'b0;
    tcCount = 0;
    firstTc = 0;
    for (int c = 1; c <= 90; c++) begin
      stepCycle();
      checkModel("period9");
      if (bus.tc === 1'b1) begin
        tcCount++;
        if (firstTc == 0) firstTc = c;
      end
    end
    vectors++;
    if (tcCount != 3 || firstTc != 30) begin
      miscompares++;
      $display("[TB] FAIL period9_tc: got %0d pulses first at %0d, expected 3 pulses first at 30",
               tcCount, firstTc);
    end

    // Randomized traffic against the reference.
    for (int c = 0; c < 1500; c++) begin
      bus.en   = ($urandom_range(0, 9) != 0);
      bus.sclr = ($urandom_range(0, 49) == 0);
      bus.load = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) lv = 20'hFFFFF - W'($urandom_range(0, 20));
      else                           lv = W'($urandom_range(0, 12));
      bus.load_val = lv;
      if ($urandom_range(0, 59) == 0) bus.period = W'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) bus.presc  = PRESC_W'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) bus.mode   = timer_mode_e'($urandom_range(0, 1));
      stepCycle();
      checkModel("random");
    end

    // Asynchronous reset in the middle of a count.
    setInputs(1'b1, 1'b0, 1'b1, 20'h00123, 20'hFFFFF, TM_PERIODIC, 8'd0);
    stepCycle();
    bus.load = 1'b0;
    runChecked("pre_async", 5);
    #3;
    clr_n = 1'b0;
    #1;
    checkOutput("async_reset", '0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("held_reset", '0, 1'b0, 1'b0);
    clr_n = 1'b1;
    runChecked("post_reset", 3);
    checkOutput("post_reset_end", 20'd3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
